clb_param: RTL and testbench
============================

Name: clb_param

Overview:
- Parametrised configurable logic block: NUM_LUT slices, each a LUT_K-input lookup table feeding a D flip-flop with clock enable and sync set/reset-to-init.
- Configuration is no longer fixed at elaboration. It is loaded at run time through a serial shift chain into a shadow register, then committed atomically to the active configuration.
- Sits in the fabric array; shift chains of neighbouring blocks daisy-chain through CFG_DOUT.

Parameters:
- LUT_K, 4, inputs per LUT (2..6)
- NUM_LUT, 2, slices per block (1..8)
- SLICE_BITS, derived 2**LUT_K+5, config bits per slice (not overridable)
- CFG_BITS, derived NUM_LUT*SLICE_BITS, total chain length

Ports:
- K  in  1  clock, all state on posedge
- RST_N  in  1  asynchronous active-low reset
- I  in  NUM_LUT*LUT_K  LUT inputs; slice j uses I[j*LUT_K +: LUT_K]
- CE  in  1  shared clock enable
- SR  in  1  shared synchronous set/reset-to-init
- O  out  NUM_LUT  slice outputs
- CFG_START  in  1  restart load (count to 0)
- CFG_EN  in  1  shift qualifier
- CFG_DIN  in  1  serial config bit
- CFG_COMMIT  in  1  transfer shadow to active
- CFG_DOUT  out  1  shadow MSB, for chaining
- CFG_READY  out  1  high in ARMED
- CFG_VALID  out  1  active config has been committed at least once

Behaviour:
- Reset (async, RST_N=0):
  - FSM to IDLE; shadow, active config, bit count and all Q to 0.
  - CFG_READY=0, CFG_VALID=0, O=0.
- Slice j active field, bits [j*SLICE_BITS +: SLICE_BITS], LSB first:
  - TRUTH[2**LUT_K-1:0]
  - OUTSEL: 0 combinational, 1 registered
  - INIT
  - SREN
  - CEEN
  - FBSEL: 1 replaces LUT input bit 0 with own Q
- LUT: F = TRUTH[idx], where idx is the slice input vector (bit 0 per FBSEL).
- Flip-flop, on posedge K when CFG_VALID=1, in priority order:
  - SREN & SR: Q <= INIT
  - else if !CEEN | CE: Q <= F
  - else hold
- Flip-flop when CFG_VALID=0: Q holds 0.
- Output: O[j] = CFG_VALID ? (OUTSEL ? Q : F) : 0.
  - Combinational path: zero cycles.
  - Registered path: one cycle.
- FSM states: IDLE, SHIFT, ARMED.
  - Any state + CFG_START: go to SHIFT, count <= 0; shadow is not cleared.
  - SHIFT + CFG_EN: shadow <= {shadow[CFG_BITS-2:0], CFG_DIN}, count += 1. First bit shifted ends at shadow MSB.
  - SHIFT + !CFG_EN: pause; count and shadow hold.
  - SHIFT, count reaches CFG_BITS (on the edge accepting the last bit): go to ARMED; CFG_READY=1 from the next cycle.
  - ARMED + CFG_EN: ignored, shadow frozen.
  - ARMED + CFG_COMMIT, on that edge:
    - active <= shadow
    - every Q <= its new INIT
    - CFG_VALID <= 1
    - FSM to IDLE
  - New function visible from the following cycle.
- CFG_COMMIT outside ARMED is ignored.
- CFG_COMMIT and CFG_START in the same cycle while ARMED: commit wins; CFG_START is ignored.
- Reconfiguration while CFG_VALID=1: the old active config keeps operating during SHIFT/ARMED until commit, so the design runs glitch-free.
- Commit edge overrides SR/CE for that cycle: Q = INIT.
- Bit count width: clog2(CFG_BITS+1); saturates, never wraps.
- CFG_DOUT = shadow[CFG_BITS-1], combinational from the register.

Decomposition:
- Shared package clb_pkg holds:
  - FSM state typedef (IDLE/SHIFT/ARMED)
  - Field offset constants: TRUTH_LSB, OUTSEL_OFS, INIT_OFS, SREN_OFS, CEEN_OFS, FBSEL_OFS
  - SLICE_BITS function of LUT_K
- One natural sub-module, clb_slice: LUT, feedback mux, flip-flop, output mux, taking its config field as a vector. It is instantiated NUM_LUT times by generate.
- clb_param keeps the config FSM, shadow and active registers.

Test Plan (LUT_K=4, NUM_LUT=2, CFG_BITS=42):
- Reset mid-shift: assert RST_N=0 after 10 bits shifted -> O=0, CFG_READY=0, CFG_VALID=0; a fresh 42-bit load is then required.
- Combinational parity: load slice0 TRUTH=0x6996, OUTSEL=0; commit; I[3:0]=4'b1011 -> O[0]=1 in the same cycle; I[3:0]=4'b1001 -> O[0]=0.
- Registered toggle counter: load slice1 TRUTH=0x5555 (F=!I0), FBSEL=1, OUTSEL=1, INIT=1, CEEN=1; commit -> O[1]=1.
  - CE=1 for 4 cycles -> O[1] sequence 0,1,0,1.
  - CE=0 -> O[1] holds.
  - SR=1 with SREN=1 -> O[1]=1 next cycle.
- Paused shift: 42 bits with CFG_EN low for 3 random gaps -> CFG_READY rises exactly after the 42nd qualified bit; extra CFG_EN bits in ARMED do not change CFG_DOUT.
- Shadow reconfig: with slice0 running parity, shift a new config (TRUTH=0x8000 AND4) -> O[0] stays parity until the commit edge, then I=4'b1111 -> O[0]=1 and I=4'b0111 -> O[0]=0.
- Commit/start collision: CFG_COMMIT and CFG_START together in ARMED -> CFG_VALID=1, FSM IDLE, CFG_READY=0; CFG_COMMIT while in SHIFT -> no effect.

Source files
------------

// File: rtl/clb_pkg.sv
// rtl/clb_pkg.sv - shared types and config field layout for the configurable logic block
//
// Purpose: FSM state encoding for the serial config loader, per-slice field
// offsets and the slice width helper used by clb_param and clb_slice.
// Slice field layout, LSB first: TRUTH[2**K-1:0], OUTSEL, INIT, SREN, CEEN, FBSEL.
package clb_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_SHIFT = 2'd1,
    CFG_ARMED = 2'd2
  } cfg_state_e;

  localparam int TRUTH_LSB = 0;
  // Control bit offsets, counted from the first bit above the truth table.
  localparam int OUTSEL_OFS = 0;
  localparam int INIT_OFS   = 1;
  localparam int SREN_OFS   = 2;
  localparam int CEEN_OFS   = 3;
  localparam int FBSEL_OFS  = 4;

  function automatic int slice_bits(input int lut_k);
    return (1 << lut_k) + 5;
  endfunction

endpackage

// File: rtl/clb_slice.sv
// rtl/clb_slice.sv - one LUT + flip-flop slice driven by its active config field
//
// Purpose: LUT_K-input lookup table with optional Q feedback on input 0, a
// D flip-flop with clock enable and sync set/reset-to-init, and an output mux.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   cfg_i            active config field for this slice
//   valid_i          active config has been committed
//   commit_i         commit edge: Q loads commit_init_i
//   commit_init_i    INIT bit of the incoming (shadow) config
//   in_i             LUT inputs
//   ce_i, sr_i       shared clock enable and set/reset-to-init
//   o_o              slice output
module clb_slice
  import clb_pkg::*;
#(
  parameter  int LUT_K = 4,
  localparam int SB    = slice_bits(LUT_K),
  localparam int TT    = 1 << LUT_K
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SB-1:0]    cfg_i,
  input  logic             valid_i,
  input  logic             commit_i,
  input  logic             commit_init_i,
  input  logic [LUT_K-1:0] in_i,
  input  logic             ce_i,
  input  logic             sr_i,
  output logic             o_o
);

  logic [TT-1:0]    truth;
  logic             outsel, init, sren, ceen, fbsel;
  logic [LUT_K-1:0] idx;
  logic             f;
  logic             q_q, q_d;

  assign truth  = cfg_i[TRUTH_LSB +: TT];
  assign outsel = cfg_i[TT + OUTSEL_OFS];
  assign init   = cfg_i[TT + INIT_OFS];
  assign sren   = cfg_i[TT + SREN_OFS];
  assign ceen   = cfg_i[TT + CEEN_OFS];
  assign fbsel  = cfg_i[TT + FBSEL_OFS];

  always_comb begin
    idx = in_i;
    if (fbsel) idx[0] = q_q;
    f = truth[idx];
  end

  // Commit beats SR/CE; an unconfigured block keeps Q at its reset value 0.
  always_comb begin
    q_d = q_q;
    if (commit_i) begin
      q_d = commit_init_i;
    end else if (valid_i) begin
      if (sren && sr_i)      q_d = init;
      else if (!ceen || ce_i) q_d = f;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= 1'b0;
    else         q_q <= q_d;
  end

  assign o_o = valid_i & (outsel ? q_q : f);

endmodule

// File: rtl/clb_param.sv
// rtl/clb_param.sv - run-time configurable logic block with serial shadow config
//
// Purpose: NUM_LUT slices whose configuration is shifted serially into a
// shadow register and committed atomically to the active register.
// Ports:
//   K, RST_N           clock, async active-low reset
//   I, CE, SR, O       fabric inputs/controls and slice outputs
//   CFG_START          restart load
//   CFG_EN, CFG_DIN    qualified serial config bit
//   CFG_COMMIT         shadow -> active (only when ARMED)
//   CFG_DOUT           shadow MSB for daisy chaining
//   CFG_READY          shadow fully loaded (ARMED)
//   CFG_VALID          active config committed at least once
module clb_param
  import clb_pkg::*;
#(
  parameter  int LUT_K      = 4,
  parameter  int NUM_LUT    = 2,
  localparam int SLICE_BITS = slice_bits(LUT_K),
  localparam int CFG_BITS   = NUM_LUT * SLICE_BITS,
  localparam int CW         = $clog2(CFG_BITS + 1)
) (
  input  logic                     K,
  input  logic                     RST_N,
  input  logic [NUM_LUT*LUT_K-1:0] I,
  input  logic                     CE,
  input  logic                     SR,
  output logic [NUM_LUT-1:0]       O,
  input  logic                     CFG_START,
  input  logic                     CFG_EN,
  input  logic                     CFG_DIN,
  input  logic                     CFG_COMMIT,
  output logic                     CFG_DOUT,
  output logic                     CFG_READY,
  output logic                     CFG_VALID
);

  cfg_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic                valid_q, valid_d;
  logic                commit;

  assign commit = (state_q == CFG_ARMED) && CFG_COMMIT;

  // Commit has priority over a simultaneous restart; a restart edge does not
  // also accept a data bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    valid_d  = valid_q;
    if (commit) begin
      active_d = shadow_q;
      valid_d  = 1'b1;
      state_d  = CFG_IDLE;
    end else if (CFG_START) begin
      state_d = CFG_SHIFT;
      cnt_d   = '0;
    end else if (state_q == CFG_SHIFT && CFG_EN) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], CFG_DIN};
      if (cnt_q != CW'(CFG_BITS)) cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(CFG_BITS - 1)) state_d = CFG_ARMED;
    end
  end

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= CFG_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      valid_q  <= valid_d;
    end
  end

  assign CFG_DOUT  = shadow_q[CFG_BITS-1];
  assign CFG_READY = (state_q == CFG_ARMED);
  assign CFG_VALID = valid_q;

  for (genvar j = 0; j < NUM_LUT; j++) begin : g_slice
    clb_slice #(.LUT_K(LUT_K)) u_slice (
      .clk_i         (K),
      .rst_ni        (RST_N),
      .cfg_i         (active_q[j*SLICE_BITS +: SLICE_BITS]),
      .valid_i       (valid_q),
      .commit_i      (commit),
      .commit_init_i (shadow_q[j*SLICE_BITS + (1 << LUT_K) + INIT_OFS]),
      .in_i          (I[j*LUT_K +: LUT_K]),
      .ce_i          (CE),
      .sr_i          (SR),
      .o_o           (O[j])
    );
  end

endmodule

// File: tb/tb_clb_param.sv
// tb/tb_clb_param.sv - self-checking bench for clb_param
module tb_clb_param;

  logic       K = 1'b0;
  logic       RST_N;
  logic [7:0] I;
  logic       CE, SR;
  logic [1:0] O;
  logic       CFG_START, CFG_EN, CFG_DIN, CFG_COMMIT;
  logic       CFG_DOUT, CFG_READY, CFG_VALID;

  clb_param #(.LUT_K(4), .NUM_LUT(2)) dut (
    .K(K), .RST_N(RST_N), .I(I), .CE(CE), .SR(SR), .O(O),
    .CFG_START(CFG_START), .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN),
    .CFG_COMMIT(CFG_COMMIT), .CFG_DOUT(CFG_DOUT),
    .CFG_READY(CFG_READY), .CFG_VALID(CFG_VALID)
  );

  always #5 K = ~K;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slice field: {FBSEL, CEEN, SREN, INIT, OUTSEL, TRUTH[15:0]}
  function automatic logic [20:0] mk(input logic [15:0] t, input logic outsel,
                                     input logic init, input logic sren,
                                     input logic ceen, input logic fbsel);
    return {fbsel, ceen, sren, init, outsel, t};
  endfunction

  // ---------------- behavioural model ----------------
  int          m_mode;   // 0 idle, 1 loading, 2 loaded
  int          m_bits;
  logic [41:0] m_shadow, m_active;
  logic        m_valid;
  logic [1:0]  m_q, m_nq;

  function automatic logic m_f(input int j);
    logic [20:0] fld;
    logic [3:0]  ix;
    fld = m_active[j*21 +: 21];
    ix  = I[j*4 +: 4];
    if (fld[20]) ix[0] = m_q[j];
    return fld[ix];
  endfunction

  function automatic logic [1:0] m_o();
    logic [1:0] r;
    for (int j = 0; j < 2; j++)
      r[j] = m_valid & (m_active[j*21+16] ? m_q[j] : m_f(j));
    return r;
  endfunction

  always @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      m_mode = 0; m_bits = 0; m_shadow = '0; m_active = '0; m_valid = 0; m_q = '0;
    end else begin
      m_nq = m_q;
      if (m_mode == 2 && CFG_COMMIT) begin
        m_active = m_shadow;
        m_valid  = 1'b1;
        m_mode   = 0;
        for (int j = 0; j < 2; j++) m_nq[j] = m_shadow[j*21+17];
      end else begin
        if (m_valid)
          for (int j = 0; j < 2; j++) begin
            if (m_active[j*21+18] && SR)         m_nq[j] = m_active[j*21+17];
            else if (!m_active[j*21+19] || CE)   m_nq[j] = m_f(j);
          end
        if (CFG_START) begin
          m_mode = 1; m_bits = 0;
        end else if (m_mode == 1 && CFG_EN) begin
          m_shadow = {m_shadow[40:0], CFG_DIN};
          m_bits++;
          if (m_bits == 42) m_mode = 2;
        end
      end
      m_q = m_nq;
    end
  end

  always @(negedge K) begin
    if (chk_en) begin
      check("model_O", {30'd0, O}, {30'd0, m_o()});
      check("model_READY", {31'd0, CFG_READY}, {31'd0, m_mode == 2});
      check("model_VALID", {31'd0, CFG_VALID}, {31'd0, m_valid});
      check("model_DOUT", {31'd0, CFG_DOUT}, {31'd0, m_shadow[41]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge K);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    CFG_EN = 1'b1; CFG_DIN = b;
    tick();
    CFG_EN = 1'b0;
  endtask

  task automatic shift_range(input logic [41:0] w, input int hi, input int lo,
                             input logic [41:0] gap_mask);
    for (int i = hi; i >= lo; i--) begin
      shift_bit(w[i]);
      if (gap_mask[i]) repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic start_load();
    CFG_START = 1'b1; tick(); CFG_START = 1'b0;
  endtask

  task automatic do_commit();
    CFG_COMMIT = 1'b1; tick(); CFG_COMMIT = 1'b0;
  endtask

  logic [41:0] wa, wb;
  logic [41:0] gaps;

  initial begin
    wa = {mk(16'h5555, 1, 1, 1, 1, 1), mk(16'h6996, 0, 0, 0, 0, 0)};
    wb = {mk(16'h5555, 1, 1, 1, 1, 1), mk(16'h8000, 0, 0, 0, 0, 0)};
    gaps = '0; gaps[30] = 1'b1; gaps[15] = 1'b1; gaps[5] = 1'b1;
    RST_N = 1'b0; I = '0; CE = 0; SR = 0;
    CFG_START = 0; CFG_EN = 0; CFG_DIN = 0; CFG_COMMIT = 0;
    repeat (2) @(posedge K);
    #1 RST_N = 1'b1;
    chk_en = 1'b1;
    check("reset_O", {30'd0, O}, 32'd0);
    check("reset_READY", {31'd0, CFG_READY}, 32'd0);
    check("reset_VALID", {31'd0, CFG_VALID}, 32'd0);

    // Reset after 10 bits, then a stray commit, then a full reload.
    start_load();
    shift_range(wa, 41, 32, '0);
    RST_N = 1'b0;
    #1;
    check("midrst_O", {30'd0, O}, 32'd0);
    check("midrst_READY", {31'd0, CFG_READY}, 32'd0);
    check("midrst_VALID", {31'd0, CFG_VALID}, 32'd0);
    RST_N = 1'b1;
    tick();
    do_commit();
    check("idle_commit_VALID", {31'd0, CFG_VALID}, 32'd0);
    start_load();
    shift_range(wa, 41, 1, '0);
    check("41bits_READY", {31'd0, CFG_READY}, 32'd0);
    shift_bit(wa[0]);
    check("42bits_READY", {31'd0, CFG_READY}, 32'd1);
    do_commit();
    check("commit_VALID", {31'd0, CFG_VALID}, 32'd1);
    check("commit_READY", {31'd0, CFG_READY}, 32'd0);
    check("commit_O1_init", {31'd0, O[1]}, 32'd1);

    // Combinational parity on slice 0.
    I = 8'b0000_1011; #1;
    check("parity_1011", {31'd0, O[0]}, 32'd1);
    I = 8'b0000_1001; #1;
    check("parity_1001", {31'd0, O[0]}, 32'd0);
    tick();

    // Registered toggle on slice 1.
    CE = 1'b1;
    tick(); check("tog_1", {31'd0, O[1]}, 32'd0);
    tick(); check("tog_2", {31'd0, O[1]}, 32'd1);
    tick(); check("tog_3", {31'd0, O[1]}, 32'd0);
    tick(); check("tog_4", {31'd0, O[1]}, 32'd1);
    CE = 1'b0;
    repeat (2) tick();
    check("tog_hold", {31'd0, O[1]}, 32'd1);
    CE = 1'b1; tick(); CE = 1'b0;
    check("tog_to0", {31'd0, O[1]}, 32'd0);
    SR = 1'b1; tick(); SR = 1'b0;
    check("sr_init", {31'd0, O[1]}, 32'd1);

    // Paused shift of AND4 while parity keeps running.
    start_load();
    shift_range(wb, 41, 20, gaps);
    I = 8'b0000_1011; #1;
    check("shadow_keeps_parity", {31'd0, O[0]}, 32'd1);
    shift_range(wb, 19, 1, gaps);
    check("paused_41_READY", {31'd0, CFG_READY}, 32'd0);
    shift_bit(wb[0]);
    check("paused_42_READY", {31'd0, CFG_READY}, 32'd1);
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(~wb[41]);
    check("armed_DOUT_frozen", {31'd0, CFG_DOUT}, {31'd0, wb[41]});
    check("armed_READY", {31'd0, CFG_READY}, 32'd1);
    I = 8'b0000_1111; #1;
    check("pre_commit_parity", {31'd0, O[0]}, 32'd0);
    do_commit();
    check("and4_1111", {31'd0, O[0]}, 32'd1);
    I = 8'b0000_0111; #1;
    check("and4_0111", {31'd0, O[0]}, 32'd0);

    // Commit and start together: commit wins.
    start_load();
    shift_range(wa, 41, 0, '0);
    CFG_COMMIT = 1'b1; CFG_START = 1'b1;
    tick();
    CFG_COMMIT = 1'b0; CFG_START = 1'b0;
    check("collide_VALID", {31'd0, CFG_VALID}, 32'd1);
    check("collide_READY", {31'd0, CFG_READY}, 32'd0);
    I = 8'b0000_0111; #1;
    check("collide_parity", {31'd0, O[0]}, 32'd1);
    tick();
    // Commit while shifting: ignored, count continues.
    start_load();
    shift_range(wb, 41, 37, '0);
    do_commit();
    check("shift_commit_READY", {31'd0, CFG_READY}, 32'd0);
    check("shift_commit_func", {31'd0, O[0]}, 32'd1);
    shift_range(wb, 36, 1, '0);
    check("resume_41_READY", {31'd0, CFG_READY}, 32'd0);
    shift_bit(wb[0]);
    check("resume_42_READY", {31'd0, CFG_READY}, 32'd1);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
